// File: rtl/pulse_width_meter_pkg.sv
// Shared types and defaults for the pulse width meter.
// Holds the FSM state encoding and default sizing.
package pulse_width_meter_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock result FIFO with occupancy count.
// A push into a full FIFO lands only if a pop frees a slot that cycle.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  output logic                     full,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time of an asynchronous input in clk cycles.
// Completed widths queue in a small FIFO; drops set a sticky flag.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_width,
  output logic             busy,
  output logic             overflow
);

  logic                   d_m;
  logic                   d_s;
  logic                   d_q;
  logic                   rise;
  logic                   fall;
  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       dout;
  logic [$clog2(DEPTH):0] fifo_cnt;

  assign rise = d_s & ~d_q;
  assign fall = ~d_s & d_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      d_m <= 1'b0;
      d_s <= 1'b0;
      d_q <= 1'b0;
    end else begin
      d_m <= d;
      d_s <= d_m;
      d_q <= d_s;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && rise) begin
            state <= MEASURE;
            count <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (!en) begin
            state <= IDLE;
          end else if (fall) begin
            state <= IDLE;
          end else if (d_s && count != '1) begin
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end

  // The push happens on the cycle the fall is seen, so the result
  // is visible one edge later, keeping latency at sync + 1.
  assign push = (state == MEASURE) & en & fall;
  assign pop  = rd_valid & rd_ready;
  assign drop = push & full & ~pop;

  sync_fifo #(
    .DATA_W (CNT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .din   (count),
    .full  (full),
    .pop   (pop),
    .dout  (dout),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != '0);
  assign rd_width = empty ? '0 : dout;
  assign busy     = (state == MEASURE);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of measured pulse-width words.
REQ-002 Parameter DEPTH, default 4: result FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  measurement enable.
REQ-006 d  input  1  monitored signal, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of the overflow flag.
REQ-008 rd_ready  input  1  consumer accepts the head result.
REQ-009 rd_valid  output  1  FIFO non-empty; a result is presented.
REQ-010 rd_width  output  CNT_W  head result: high-time of one pulse in clk cycles.
REQ-011 busy  output  1  high while in MEASURE.
REQ-012 overflow  output  1  sticky; a completed pulse was dropped because the FIFO was full.

Function
REQ-013 d SHALL pass through a 2-flop synchronizer (d_s), plus one history flop (d_q); rise = d_s & ~d_q, fall = ~d_s & d_q.
REQ-014 FSM states: IDLE, MEASURE.
- IDLE -> MEASURE on rise & en; count loads 1.
- MEASURE, d_s high: count +1 per cycle, saturating at 2^CNT_W-1 (no wrap).
- MEASURE -> IDLE on fall: push count into FIFO.
- MEASURE -> IDLE when en goes low: abort, no push.
REQ-015 A rise seen while en is low, or while in IDLE with d_s already high after en rises, SHALL be ignored; measurement starts only on a fresh rising edge.
REQ-016 A pulse held high for N clk cycles at d (setup met) SHALL yield rd_width = N.
REQ-017 Latency: rd_valid SHALL assert 3 cycles after d falls (2 sync + 1 push), FIFO empty before.
REQ-018 Handshake: an entry pops on rd_valid & rd_ready. rd_width is stable while rd_valid & ~rd_ready.
REQ-019 Push when the FIFO is full and not popping in the same cycle: result discarded, overflow set.
REQ-020 Push when the FIFO is full and popping in the same cycle: both occur; no overflow.
REQ-021 Push and pop on an empty FIFO in the same cycle: push only.
REQ-022 Pointers wrap modulo DEPTH. Full and empty are distinguished by an occupancy count of width log2(DEPTH)+1.
REQ-023 overflow clears on clr. If clr and a new drop occur in the same cycle, overflow SHALL stay set.
REQ-024 Back-to-back pulses separated by >=1 synchronized low cycle SHALL each be measured.

Reset
REQ-025 When res is asserted, the following SHALL clear asynchronously:
- sync and history flops to 0
- FSM to IDLE and count to 0
- FIFO pointers and occupancy to 0
- rd_valid, busy and overflow to 0
REQ-026 rd_width SHALL read 0 after reset.
REQ-027 Reset during MEASURE SHALL discard the partial pulse; no entry appears after release.
REQ-028 The first rise is detected only after reset release, with d_s and d_q having settled.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the default CNT_W and DEPTH constants.
REQ-030 The FIFO SHALL be a sub-module, sync_fifo (parameters DATA_W, DEPTH), with push/full/pop/empty/count ports. Synchronizer, edge detect, FSM and counter stay in the top module.

Verification
REQ-031 en=1, d high 5 cycles, rd_ready=1 -> one result, rd_width=5; rd_valid asserts 3 cycles after the falling edge.
REQ-032 CNT_W=4, d high 20 cycles -> rd_width=15 (saturated).
REQ-033 rd_ready=0, 5 pulses of widths 1..5 -> first 4 queued, overflow=1; then drain with rd_ready=1 -> results 1,2,3,4 in order; clr -> overflow=0.
REQ-034 Pulse starts, en drops after 3 high cycles -> busy falls, no result; d held high while en is re-raised -> no measurement until the next rising edge.
REQ-035 res pulsed asynchronously mid-pulse -> busy, rd_valid and overflow go 0 immediately; no result after release.
REQ-036 FIFO full with rd_ready=1 and a pulse completing in the same cycle -> occupancy unchanged, overflow stays 0, order preserved.
